// File: rtl/vdp_interrupt.sv
// VDP interrupt stage: frame (F) and line (FH) status flags plus the registered int_n line.
// Optional frame counter enabled by defining VDP_INT_FRAME_CNT_EN; otherwise frame_cnt reads 0.
`timescale 1ns/1ps

module vdp_interrupt #(
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk21m,
    input  logic                   reset_n,
    input  logic                   v_blanking_start,
    input  logic                   hsync,
    input  logic                   enahsync,
    input  logic                   reg_r1_ie0,
    input  logic                   reg_r0_ie1,
    input  logic                   clr_vsync_int,
    input  logic                   clr_hsync_int,
    output logic                   vsync_int_flag,
    output logic                   hsync_int_flag,
    output logic                   int_n,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } flag_state_t;

    flag_state_t f_state, f_next;
    flag_state_t fh_state, fh_next;

    logic hsync_d;
    logic hsync_rise;
    logic line_event;
    logic frame_event;

    assign hsync_rise  = hsync & ~hsync_d;
    assign line_event  = hsync_rise & enahsync;
    assign frame_event = v_blanking_start;

    // hsync_d resets high so a line already in sync at release is not seen as a rising edge.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk21m or negedge reset_n) begin
        if (!reset_n) begin
            hsync_d  <= 1'b1;
            f_state  <= IDLE;
            fh_state <= IDLE;
        end else begin
            hsync_d  <= hsync;
            f_state  <= f_next;
            fh_state <= fh_next;
        end
    end

    // Set has priority over clear so an event coinciding with a status read is never lost.
    // NOTE: each next-state variable gets a default first, so no latch is inferred.
    always_comb begin
        f_next  = f_state;
        fh_next = fh_state;
        case (f_state)
            IDLE: if (frame_event) f_next = PEND;
            PEND: if (clr_vsync_int && !frame_event) f_next = IDLE;
        endcase
        case (fh_state)
            IDLE: if (line_event) fh_next = PEND;
            PEND: if (clr_hsync_int && !line_event) fh_next = IDLE;
        endcase
    end

    always_comb begin
        vsync_int_flag = (f_state == PEND);
        hsync_int_flag = (fh_state == PEND);
    end

    // Enables gate only the request line; the flags themselves are always recorded.
    always_ff @(posedge clk21m or negedge reset_n) begin
        if (!reset_n) begin
            int_n <= 1'b1;
        end else begin
            int_n <= ~((vsync_int_flag & reg_r1_ie0) | (hsync_int_flag & reg_r0_ie1));
        end
    end

`ifdef VDP_INT_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    always_ff @(posedge clk21m or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
        end else if (v_blanking_start) begin
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule
